layer_seq: RTL and testbench

Parametrised control sequencer for one CNN layer. It is the successor to the fixed pad/im2col/dot/bias phase FSM. It adds optional phases, looping over output-channel tiles, explicit start/done handshakes with each datapath sub-unit, abort, and error flagging. It sits between the network-level controller (run/done) and the layer datapath units (zero-pad, im2col, dot-product, bias).

---
 rtl/layer_seq_pkg.sv | 27 ++
 rtl/layer_seq_tile_cnt.sv | 38 +++
 rtl/layer_seq.sv | 150 +++++++++++++++
 tb/tb_layer_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared definitions for the layer sequencer: state codes, default sizes, decode helpers.
package layer_seq_pkg;

    localparam int unsigned TILE_W_DEF = 4;
    localparam int unsigned Q_W        = 3;

    typedef enum logic [2:0] {
        CIDL = 3'd0,
        ZPAD = 3'd1,
        IM2C = 3'd2,
        DOTP = 3'd3,
        BIAS = 3'd4,
        FINI = 3'd5
    } state_t;

    // Codes at or above this value are not valid states
    localparam logic [Q_W-1:0] ILL_LO = 3'd6;

    function automatic logic is_working(input logic [Q_W-1:0] s);
        return (s == ZPAD) || (s == IM2C) || (s == DOTP) || (s == BIAS);
    endfunction

    function automatic logic is_illegal(input logic [Q_W-1:0] s);
        return s >= ILL_LO;
    endfunction

endpackage

// File: rtl/layer_seq_tile_cnt.sv
// Output-channel tile index counter with terminal-count compare against max(tiles,1).
module layer_seq_tile_cnt
    import layer_seq_pkg::*;
#(
    parameter int unsigned TILE_W = TILE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [TILE_W-1:0] tiles,
    output logic [TILE_W-1:0] idx,
    output logic              last_c
);

    logic [TILE_W-1:0] tiles_eff;

    // A tile count of zero runs the layer once
    always_comb begin
        tiles_eff = tiles;
        if (tiles == '0) begin
            tiles_eff = TILE_W'(1);
        end
        last_c = (idx == tiles_eff - TILE_W'(1));
    end

    // Index register; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + TILE_W'(1);
        end
    end

endmodule

// File: rtl/layer_seq.sv
// Per-layer control sequencer: ZPAD/IM2C/DOTP/BIAS phases with tile looping,
// start/load handshake, abort and sticky protocol error.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int unsigned TILE_W = TILE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              abort,
    input  logic              load,
    input  logic              cfg_pad_en,
    input  logic              cfg_bias_en,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic [2:0]        q,
    output logic              start,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            st;
    logic              pad_en_r;
    logic              bias_en_r;
    logic [TILE_W-1:0] tiles_r;

    logic working_c;
    logic illegal_c;
    logic abort_hit_c;
    logic acc_c;
    logic tile_end_c;
    logic last_c;
    logic cnt_clr_c;
    logic cnt_inc_c;

    assign q = st;

    // Handshake decode: which load is accepted, and what the tile counter does
    always_comb begin
        working_c   = is_working(st);
        illegal_c   = is_illegal(st);
        abort_hit_c = abort && (st != CIDL);
        acc_c       = load && !start && working_c && !abort_hit_c;
        tile_end_c  = acc_c && (((st == DOTP) && !bias_en_r) || (st == BIAS));
        cnt_clr_c   = abort_hit_c || illegal_c || ((st == CIDL) && run);
        cnt_inc_c   = tile_end_c && !last_c;
    end

    layer_seq_tile_cnt #(
        .TILE_W (TILE_W)
    ) u_tile_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_c),
        .inc    (cnt_inc_c),
        .tiles  (tiles_r),
        .idx    (tile_idx),
        .last_c (last_c)
    );

    // Phase FSM with registered start/busy/done/err and latched layer config
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= CIDL;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pad_en_r  <= 1'b0;
            bias_en_r <= 1'b0;
            tiles_r   <= '0;
        end else begin
            start <= 1'b0;
            if (abort_hit_c) begin
                st   <= CIDL;
                busy <= 1'b0;
                done <= 1'b0;
            end else if (illegal_c) begin
                st   <= CIDL;
                busy <= 1'b0;
                done <= 1'b0;
                err  <= 1'b1;
            end else begin
                case (st)
                    CIDL: begin
                        if (run) begin
                            pad_en_r  <= cfg_pad_en;
                            bias_en_r <= cfg_bias_en;
                            tiles_r   <= cfg_tiles;
                            err       <= 1'b0;
                            start     <= 1'b1;
                            busy      <= 1'b1;
                            if (cfg_pad_en) begin
                                st <= ZPAD;
                            end else begin
                                st <= IM2C;
                            end
                        end
                    end
                    ZPAD: begin
                        if (acc_c) begin
                            st    <= IM2C;
                            start <= 1'b1;
                        end
                    end
                    IM2C: begin
                        if (acc_c) begin
                            st    <= DOTP;
                            start <= 1'b1;
                        end
                    end
                    DOTP: begin
                        if (acc_c && bias_en_r) begin
                            st    <= BIAS;
                            start <= 1'b1;
                        end
                    end
                    FINI: begin
                        if (!run) begin
                            st   <= CIDL;
                            busy <= 1'b0;
                            done <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase

                // End of a tile: either loop back to DOTP or finish the layer
                if (tile_end_c) begin
                    if (last_c) begin
                        st   <= FINI;
                        done <= 1'b1;
                    end else begin
                        st    <= DOTP;
                        start <= 1'b1;
                    end
                end

                // A load that collides with the start pulse is a protocol violation
                if (working_c && load && start) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_seq.sv
// Self-checking bench for layer_seq: directed table, hand sequences and a
// randomized run against a phase-list reference model.
module tb_layer_seq;

    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          abort;
    logic          load;
    logic          cfg_pad_en;
    logic          cfg_bias_en;
    logic [TW-1:0] cfg_tiles;
    logic [2:0]    q;
    logic          start;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          done;
    logic          err;

    layer_seq #(.TILE_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .abort       (abort),
        .load        (load),
        .cfg_pad_en  (cfg_pad_en),
        .cfg_bias_en (cfg_bias_en),
        .cfg_tiles   (cfg_tiles),
        .q           (q),
        .start       (start),
        .tile_idx    (tile_idx),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the remaining phases of the layer as a list of (code, tile)
    int ph[$];
    int pt[$];
    int m_q     = 0;
    int m_tile  = 0;
    bit m_start = 1'b0;
    bit m_err   = 1'b0;

    task automatic model_step();
        int nq;
        bit ns;
        int te;
        nq = m_q;
        ns = 1'b0;
        if (rst) begin
            m_q = 0; m_start = 1'b0; m_tile = 0; m_err = 1'b0;
            ph.delete(); pt.delete();
            return;
        end
        if (abort && m_q != 0) begin
            nq = 0; m_tile = 0;
            ph.delete(); pt.delete();
        end else if (m_q == 0) begin
            if (run) begin
                ph.delete(); pt.delete();
                te = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
                if (cfg_pad_en) begin ph.push_back(1); pt.push_back(0); end
                ph.push_back(2); pt.push_back(0);
                for (int t = 0; t < te; t++) begin
                    ph.push_back(3); pt.push_back(t);
                    if (cfg_bias_en) begin ph.push_back(4); pt.push_back(t); end
                end
                m_err = 1'b0; m_tile = 0; nq = ph[0]; ns = 1'b1;
            end
        end else if (m_q == 5) begin
            if (!run) nq = 0;
        end else if (load) begin
            if (m_start) begin
                m_err = 1'b1;
            end else begin
                void'(ph.pop_front());
                void'(pt.pop_front());
                if (ph.size() == 0) begin
                    nq = 5;
                end else begin
                    nq = ph[0]; m_tile = pt[0]; ns = 1'b1;
                end
            end
        end
        m_q = nq;
        m_start = ns;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".q"},     int'(q),        m_q);
        chk({tag, ".start"}, int'(start),    int'(m_start));
        chk({tag, ".tile"},  int'(tile_idx), m_tile);
        chk({tag, ".busy"},  int'(busy),     int'(m_q != 0));
        chk({tag, ".done"},  int'(done),     int'(m_q == 5));
        chk({tag, ".err"},   int'(err),      int'(m_err));
    endtask

    // One clock: model advances at the edge, outputs are sampled 1 time unit later
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step(input string tag, input bit r, input bit a, input bit l);
        run = r; abort = a; load = l;
        cyc();
        check_model(tag);
    endtask

    task automatic set_cfg(input bit pad, input bit bias, input int tiles);
        cfg_pad_en = pad; cfg_bias_en = bias; cfg_tiles = TW'(tiles);
    endtask

    int pulses;
    int tile_log[$];

    // Run one layer with loads issued 'gap' cycles after each start pulse
    task automatic run_layer(input string tag, input int gap);
        int  since;
        bit  fin;
        since = 0; fin = 1'b0; pulses = 0;
        tile_log.delete();
        run = 1'b1; abort = 1'b0; load = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            check_model(tag);
            if (start) begin
                pulses++;
                tile_log.push_back(int'(tile_idx));
                since = 0;
            end else begin
                since++;
            end
            if (m_q == 5) begin
                fin = 1'b1;
                break;
            end
            load = (m_q >= 1 && m_q <= 4 && since >= gap);
        end
        load = 1'b0;
        if (!fin) chk({tag, ".timeout"}, 0, 1);
        step({tag, ".fini_hold"}, 1'b1, 1'b0, 1'b0);
        chk({tag, ".fini_done"}, int'(done), 1);
        step({tag, ".drop_run"}, 1'b0, 1'b0, 1'b0);
        chk({tag, ".idle_q"},    int'(q),    0);
        chk({tag, ".idle_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        bit       run;
        bit       load;
        int       q;
        bit       start;
        int       tile;
        bit       err;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input bit r, input bit l, input int eq, input bit es,
                                input int et, input bit ee);
        vec_t v;
        v.run = r; v.load = l; v.q = eq; v.start = es; v.tile = et; v.err = ee;
        return v;
    endfunction

    initial begin
        // Full flow pad=1 bias=1 tiles=1, load three cycles after each start
        tbl[0]  = mk(1, 0, 1, 1, 0, 0);
        tbl[1]  = mk(1, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 2, 1, 0, 0);
        tbl[4]  = mk(1, 0, 2, 0, 0, 0);
        tbl[5]  = mk(1, 0, 2, 0, 0, 0);
        tbl[6]  = mk(1, 1, 3, 1, 0, 0);
        tbl[7]  = mk(1, 0, 3, 0, 0, 0);
        tbl[8]  = mk(1, 0, 3, 0, 0, 0);
        tbl[9]  = mk(1, 1, 4, 1, 0, 0);
        tbl[10] = mk(1, 0, 4, 0, 0, 0);
        tbl[11] = mk(1, 0, 4, 0, 0, 0);
        tbl[12] = mk(1, 1, 5, 0, 0, 0);
        tbl[13] = mk(1, 0, 5, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0);

        rst = 1'b1; run = 1'b0; abort = 1'b0; load = 1'b0;
        set_cfg(1'b0, 1'b0, 0);
        cyc();
        cyc();
        chk("reset.q", int'(q), 0);
        chk("reset.start", int'(start), 0);
        chk("reset.tile", int'(tile_idx), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.err", int'(err), 0);
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, 1'b0);

        // Table-driven full flow
        set_cfg(1'b1, 1'b1, 1);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            run = tbl[i].run; load = tbl[i].load; abort = 1'b0;
            cyc();
            chk($sformatf("tbl%0d.q", i),     int'(q),        tbl[i].q);
            chk($sformatf("tbl%0d.start", i), int'(start),    int'(tbl[i].start));
            chk($sformatf("tbl%0d.tile", i),  int'(tile_idx), tbl[i].tile);
            chk($sformatf("tbl%0d.busy", i),  int'(busy),     int'(tbl[i].q != 0));
            chk($sformatf("tbl%0d.done", i),  int'(done),     int'(tbl[i].q == 5));
            chk($sformatf("tbl%0d.err", i),   int'(err),      int'(tbl[i].err));
            if (start) pulses++;
        end
        chk("tbl.pulses", pulses, 4);

        // pad=0 bias=0 tiles=3: IM2C then three DOTP passes
        set_cfg(1'b0, 1'b0, 3);
        run_layer("t3", 2);
        chk("t3.pulses", pulses, 4);
        if (tile_log.size() == 4) begin
            chk("t3.tile0", tile_log[0], 0);
            chk("t3.tile1", tile_log[1], 0);
            chk("t3.tile2", tile_log[2], 1);
            chk("t3.tile3", tile_log[3], 2);
        end else begin
            chk("t3.tile_log_size", tile_log.size(), 4);
        end

        // cfg_tiles=0 behaves as one tile
        set_cfg(1'b0, 1'b1, 0);
        run_layer("t0", 1);
        chk("t0.pulses", pulses, 3);
        chk("t0.tile", int'(tile_idx), 0);

        // abort together with load in DOTP at tile 1
        set_cfg(1'b0, 1'b0, 3);
        step("ab", 1'b1, 1'b0, 1'b0);
        step("ab", 1'b1, 1'b0, 1'b0);
        step("ab", 1'b1, 1'b0, 1'b1);
        step("ab", 1'b1, 1'b0, 1'b0);
        step("ab", 1'b1, 1'b0, 1'b1);
        step("ab", 1'b1, 1'b0, 1'b0);
        chk("ab.pre_tile", int'(tile_idx), 1);
        chk("ab.pre_q", int'(q), 3);
        step("ab", 1'b1, 1'b1, 1'b1);
        chk("ab.q", int'(q), 0);
        chk("ab.tile", int'(tile_idx), 0);
        chk("ab.start", int'(start), 0);
        chk("ab.err", int'(err), 0);
        step("ab", 1'b0, 1'b0, 1'b0);

        // load during the IM2C start cycle
        set_cfg(1'b0, 1'b1, 1);
        step("ls", 1'b1, 1'b0, 1'b0);
        chk("ls.start", int'(start), 1);
        step("ls", 1'b1, 1'b0, 1'b1);
        chk("ls.q_hold", int'(q), 2);
        chk("ls.err_set", int'(err), 1);
        step("ls", 1'b1, 1'b0, 1'b1);
        chk("ls.q_adv", int'(q), 3);
        chk("ls.err_hold", int'(err), 1);
        step("ls", 1'b1, 1'b0, 1'b0);
        step("ls", 1'b0, 1'b1, 1'b0);
        chk("ls.err_abort", int'(err), 1);
        step("ls", 1'b0, 1'b0, 1'b0);
        chk("ls.err_idle", int'(err), 1);
        step("ls", 1'b1, 1'b0, 1'b0);
        chk("ls.err_clear", int'(err), 0);
        step("ls", 1'b0, 1'b1, 1'b0);

        // rst mid-BIAS with run held high
        set_cfg(1'b1, 1'b1, 2);
        step("rs", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("rs", 1'b1, 1'b0, 1'b0);
            step("rs", 1'b1, 1'b0, 1'b1);
        end
        chk("rs.in_bias", int'(q), 4);
        rst = 1'b1;
        step("rs", 1'b1, 1'b0, 1'b0);
        chk("rs.q", int'(q), 0);
        chk("rs.start", int'(start), 0);
        chk("rs.tile", int'(tile_idx), 0);
        chk("rs.busy", int'(busy), 0);
        chk("rs.done", int'(done), 0);
        chk("rs.err", int'(err), 0);
        rst = 1'b0;
        step("rs", 1'b1, 1'b0, 1'b0);
        chk("rs.restart_q", int'(q), 1);
        chk("rs.restart_start", int'(start), 1);
        step("rs", 1'b0, 1'b1, 1'b0);

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 79) == 0);
            run   = ($urandom_range(0, 9) != 0);
            load  = ($urandom_range(0, 99) < 45);
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)));
            cyc();
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
